// File: rtl/cpu_controller.sv
// cpu_controller: multi-cycle sequencer for the 4-bit accumulator datapath.
// Runs FETCH -> DECODE -> EXECUTE per instruction. It drives the datapath controls
// combinationally in EXECUTE and presents register values on a valid/ready port.
module cpu_controller #(
  parameter logic [3:0] RESET_PC = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       halted,
  output logic [3:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       dp_mux_sel,
  output logic       dp_load,
  output logic [1:0] dp_alu_sel,
  output logic [3:0] dp_mux_data,
  output logic [3:0] dp_alu_b,
  input  logic       dp_carry,
  input  logic [3:0] dp_reg,
  output logic [3:0] out_data,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExecute,
    StHalt
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       carry_q, carry_d;

  logic [3:0] op;
  logic [3:0] imm;
  logic [3:0] pc_inc;

  assign op        = ir_q[7:4];
  assign imm       = ir_q[3:0];
  assign pc_inc    = pc_q + 4'd1;  // natural 4-bit wrap F -> 0
  assign imem_addr = pc_q;
  assign busy      = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExecute);
  assign halted    = (state_q == StHalt);

  // Next-state, pc/ir/carry updates and EXECUTE-phase datapath controls.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    carry_d     = carry_q;
    dp_mux_sel  = 1'b0;
    dp_load     = 1'b0;
    dp_alu_sel  = 2'b00;
    dp_mux_data = 4'h0;
    dp_alu_b    = 4'h0;
    out_data    = 4'h0;
    out_valid   = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d = StFetch;
          pc_d    = RESET_PC;
          carry_d = 1'b0;
        end
      end
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StExecute;
        ir_d    = imem_data;
      end
      StExecute: begin
        state_d = StFetch;
        pc_d    = pc_inc;
        casez (op)
          4'b0001: begin
            dp_mux_data = imm;
            dp_load     = 1'b1;
          end
          4'b01??: begin
            dp_alu_sel = op[1:0];
            dp_alu_b   = imm;
            dp_mux_sel = 1'b1;
            dp_load    = 1'b1;
            carry_d    = dp_carry;
          end
          4'b1000: pc_d = imm;
          4'b1001: if (carry_q) pc_d = imm;
          4'b1010: if (dp_reg == 4'h0) pc_d = imm;
          4'b1011: begin
            out_valid = 1'b1;
            out_data  = dp_reg;
            // Stall in EXECUTE until the consumer takes the value.
            if (!out_ready) begin
              state_d = StExecute;
              pc_d    = pc_q;
            end
          end
          4'b1111: begin
            state_d = StHalt;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      default: state_d = StIdle;
    endcase

    // A reset edge must not load the datapath register or complete a transfer.
    if (rst) begin
      dp_load   = 1'b0;
      out_valid = 1'b0;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller with a behavioural datapath, a registered
// instruction memory, and a scoreboard queue of expected OUT values.
module tb_cpu_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       halted;
  logic [3:0] imem_addr;
  logic [7:0] imem_data;
  logic       dp_mux_sel;
  logic       dp_load;
  logic [1:0] dp_alu_sel;
  logic [3:0] dp_mux_data;
  logic [3:0] dp_alu_b;
  logic       dp_carry;
  logic [3:0] dp_reg;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] mem [16];
  logic [4:0] alu_full;
  logic [3:0] exp_q [$];
  int         checks;
  int         failures;
  int         valid_cycles;

  cpu_controller #(.RESET_PC(4'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .halted     (halted),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dp_mux_sel (dp_mux_sel),
    .dp_load    (dp_load),
    .dp_alu_sel (dp_alu_sel),
    .dp_mux_data(dp_mux_data),
    .dp_alu_b   (dp_alu_b),
    .dp_carry   (dp_carry),
    .dp_reg     (dp_reg),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: address registered, data one cycle later.
  always_ff @(posedge clk) imem_data <= mem[imem_addr];

  // Datapath model: 00 ADD, 01 SUB, 10 AND, 11 OR.
  always_comb begin
    alu_full = 5'h00;
    case (dp_alu_sel)
      2'b00:   alu_full = {1'b0, dp_reg} + {1'b0, dp_alu_b};
      2'b01:   alu_full = {1'b0, dp_reg} - {1'b0, dp_alu_b};
      2'b10:   alu_full = {1'b0, dp_reg & dp_alu_b};
      default: alu_full = {1'b0, dp_reg | dp_alu_b};
    endcase
  end
  assign dp_carry = alu_full[4];

  always_ff @(posedge clk) begin
    if (dp_load) dp_reg <= dp_mux_sel ? alu_full[3:0] : dp_mux_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshake mid-cycle, then advance to 1 after the next edge.
  task automatic tick();
    logic [3:0] e;
    #3;
    if (out_valid) valid_cycles++;
    if (out_valid && out_ready) begin
      chk("sb_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic run_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    valid_cycles = 0;
    rst          = 1'b1;
    start        = 1'b0;
    out_ready    = 1'b1;
    clear_mem();

    // Reset state, and start ignored while rst is held.
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_load", 32'(dp_load), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_ctrl", 32'({dp_mux_sel, dp_alu_sel, dp_mux_data, dp_alu_b, out_data}), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_start_idle", 32'({busy, halted}), 32'd0);
    rst = 1'b0;
    tick();

    // LDI 5, ADD 3, OUT, HALT.
    mem[0] = 8'h15; mem[1] = 8'h43; mem[2] = 8'hB0; mem[3] = 8'hF0;
    exp_q.push_back(4'h8);
    valid_cycles = 0;
    run_start();
    chk("fetch_busy", 32'(busy), 32'd1);
    tick();
    tick();
    chk("ldi_ctrl", 32'({dp_load, dp_mux_sel, dp_mux_data}), 32'({1'b1, 1'b0, 4'h5}));
    tick();
    tick();
    tick();
    chk("add_ctrl", 32'({dp_load, dp_mux_sel, dp_alu_sel, dp_alu_b}),
        32'({1'b1, 1'b1, 2'b00, 4'h3}));
    repeat (6) tick();
    chk("halt_not_yet", 32'(halted), 32'd0);
    tick();
    chk("halt_at_12", 32'(halted), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("out_valid_once", 32'(valid_cycles), 32'd1);
    chk("sb_drained1", 32'(exp_q.size()), 32'd0);

    // Carry taken: LDI F, ADD 1, JC 5, OUT, HALT, 5: OUT, HALT.
    clear_mem();
    mem[0] = 8'h1F; mem[1] = 8'h41; mem[2] = 8'h95; mem[3] = 8'hB0;
    mem[4] = 8'hF0; mem[5] = 8'hB0; mem[6] = 8'hF0;
    exp_q.push_back(4'h0);
    run_start();
    repeat (9) tick();
    chk("jc_taken_pc", 32'(imem_addr), 32'd5);
    repeat (6) tick();
    chk("jc_taken_halt", 32'(halted), 32'd1);
    chk("sb_drained2", 32'(exp_q.size()), 32'd0);

    // Carry not taken: ADD 0 leaves carry clear.
    mem[1] = 8'h40;
    exp_q.push_back(4'hF);
    run_start();
    repeat (9) tick();
    chk("jc_not_taken_pc", 32'(imem_addr), 32'd3);
    repeat (6) tick();
    chk("jc_nt_halt", 32'(halted), 32'd1);
    chk("sb_drained3", 32'(exp_q.size()), 32'd0);

    // JZ taken / not taken.
    clear_mem();
    mem[0] = 8'h10; mem[1] = 8'hAA; mem[2] = 8'hF0; mem[10] = 8'hF0;
    run_start();
    repeat (6) tick();
    chk("jz_taken_pc", 32'(imem_addr), 32'hA);
    repeat (3) tick();
    chk("jz_taken_halt", 32'(halted), 32'd1);
    mem[0] = 8'h11;
    run_start();
    repeat (6) tick();
    chk("jz_not_taken_pc", 32'(imem_addr), 32'd2);
    repeat (3) tick();
    chk("jz_nt_halt", 32'(halted), 32'd1);

    // OUT backpressure; start while busy must be ignored.
    clear_mem();
    mem[0] = 8'h17; mem[1] = 8'hB0; mem[2] = 8'hF0;
    exp_q.push_back(4'h7);
    out_ready = 1'b0;
    run_start();
    repeat (5) tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data", 32'(out_data), 32'd7);
    valid_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      start = (i == 1);
      tick();
      chk("bp_hold", 32'({out_valid, out_data, imem_addr, busy, dp_load}),
          32'({1'b1, 4'h7, 4'h1, 1'b1, 1'b0}));
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_after_addr", 32'(imem_addr), 32'd2);
    chk("bp_after_valid", 32'(out_valid), 32'd0);
    chk("bp_valid_cycles", 32'(valid_cycles), 32'd5);
    repeat (3) tick();
    chk("bp_halt", 32'(halted), 32'd1);
    chk("sb_drained4", 32'(exp_q.size()), 32'd0);

    // 16 NOPs: pc wraps back to 0.
    clear_mem();
    run_start();
    chk("wrap_start", 32'(imem_addr), 32'd0);
    repeat (45) tick();
    chk("wrap_f", 32'(imem_addr), 32'hF);
    repeat (3) tick();
    chk("wrap_0", 32'({busy, imem_addr}), 32'({1'b1, 4'h0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Reset during EXECUTE of ADD: no register load.
    mem[0] = 8'h13; mem[1] = 8'h4F; mem[2] = 8'hF0;
    run_start();
    repeat (5) tick();
    chk("abort_pre_load", 32'(dp_load), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_reg", 32'(dp_reg), 32'd3);
    chk("abort_idle", 32'({busy, halted}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
# cpu_controller

- Sequencer for the 4-bit accumulator datapath (input mux, 4-bit register, 2-op-select ALU with carry).
- Fetches 8-bit instructions from a small synchronous instruction memory, decodes them, and drives the datapath mux select, register load, ALU select and operands.
- Keeps a carry flag, executes conditional jumps, and emits register values over a valid/ready output port.
- Sits directly above the datapath in the CPU top level.

## Interface
Parameters:
- RESET_PC, 4'h0, PC value loaded on reset and on every start.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin execution at RESET_PC; honoured only in IDLE or HALT
- busy  out  1  high in FETCH, DECODE, EXECUTE
- halted  out  1  high in HALT
- imem_addr  out  4  instruction address, driven from pc
- imem_data  in  8  instruction word, valid one cycle after imem_addr is presented
- dp_mux_sel  out  1  0 = register input from dp_mux_data, 1 = from ALU result
- dp_load  out  1  datapath register load enable
- dp_alu_sel  out  2  ALU operation select; 2'b00 = ADD in the team ALU
- dp_mux_data  out  4  immediate to the mux data input
- dp_alu_b  out  4  immediate to the ALU B operand
- dp_carry  in  1  ALU carry_out
- dp_reg  in  4  datapath register value
- out_data  out  4  output value
- out_valid  out  1  output handshake valid
- out_ready  in  1  output handshake ready

## Operation
- Instruction format: op = ir[7:4], imm = ir[3:0].
- 0000 NOP: no effect.
- 0001 LDI: dp_mux_sel=0, dp_mux_data=imm, dp_load=1.
- 01ss ALU: dp_alu_sel=ss, dp_alu_b=imm, dp_mux_sel=1, dp_load=1; carry_flag<=dp_carry.
- 1000 JMP: pc<=imm.
- 1001 JC: pc<=imm if carry_flag, else pc+1.
- 1010 JZ: pc<=imm if dp_reg==0, else pc+1.
- 1011 OUT: out_data=dp_reg, out_valid=1 until accepted.
- 1111 HALT: go to HALT; pc is not advanced.
- 1100–1110: treated as NOP.
- States: IDLE, FETCH, DECODE, EXECUTE, HALT.
  - IDLE/HALT -start-> FETCH; pc<=RESET_PC, carry_flag<=0.
  - FETCH -> DECODE.
  - DECODE -> EXECUTE; ir<=imem_data.
  - EXECUTE -> FETCH, except HALT -> HALT, and OUT without out_ready stays in EXECUTE.
- pc<=pc+1 at the end of EXECUTE for all non-jump, non-HALT ops; wraps 4'hF -> 4'h0.
- Outside EXECUTE: dp_load=0, out_valid=0, dp_mux_sel=0, dp_alu_sel=0, dp_mux_data=0, dp_alu_b=0.
- The datapath register has no reset; programs must LDI before first use.

## Timing
- Reset values: state IDLE, pc=RESET_PC, ir=0, carry_flag=0; busy=0, halted=0, out_valid=0, dp_load=0, all other outputs 0.
- rst mid-instruction aborts it immediately; no load or flag update occurs on the reset edge.
- imem_addr=pc throughout FETCH; the memory registers the address, and imem_data is sampled on the DECODE edge.
- Each instruction takes exactly 3 cycles (FETCH, DECODE, EXECUTE), plus OUT stall cycles.
- dp_* controls are combinational from state and ir during EXECUTE.
- The register update and carry_flag capture occur on the edge that ends EXECUTE; dp_carry is sampled in that same cycle.
- OUT:
  - The transfer completes on the edge where out_valid&&out_ready; with out_ready already high, OUT takes 3 cycles.
  - out_data stays stable while stalled, because dp_load=0.
- start while busy is ignored. start and rst together: rst wins.
- JC directly after an ALU op sees the new carry_flag.
- Back-to-back instructions have no bubble beyond the 3-cycle cadence.

## Test plan
- Reset: assert rst 2 cycles -> all outputs 0, state IDLE; start with rst held -> remains IDLE.
- Program [LDI 5, ADD(00) 3, OUT, HALT], out_ready=1 -> out_data=8 with out_valid for 1 cycle; halted=1 after 12 cycles from start.
- Carry: [LDI F, ADD 1, JC 5, …, 5: OUT] -> jump taken, out_data=0; repeat with ADD 0 -> not taken, pc=3.
- JZ: LDI 0 then JZ A -> pc=A; LDI 1 then JZ A -> pc+1.
- OUT backpressure: out_ready low 4 cycles -> out_valid held 4+ cycles, out_data stable, no fetch until accepted.
- Wrap and abort:
  - 16 NOPs from pc=0 -> imem_addr returns to 0.
  - rst asserted in EXECUTE of an ALU op -> dp_reg unchanged, carry_flag=0.
